// File: rtl/dif_prod_imp_unit.sv
// ---------------------------------------------------------------------------
// dif_prod_imp_unit
//
// Purpose:
//   Three arithmetic paths sharing one pair of signed operands:
//     - difference n1-n2, registered with 1-cycle latency, overflow flag
//     - product n1*n2 (low W bits of the full 2W-bit product), registered
//       with 1-cycle latency, overflow flag
//     - quotient n1/n2 from a sequential restoring divider (IDLE/RUN/DONE),
//       W+1 cycles latency, truncation toward zero, error flag for a zero
//       divisor or the -2^(W-1)/-1 case
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   n1, n2         signed operands (W bits)
//   valid_in       operands valid, sampled on the rising edge
//   d_out_dif      registered difference         (+ ovrflow_dif,  valid_out_dif)
//   d_out_prod     registered product, low W bits (+ ovrflow_prod, valid_out_prod)
//   d_out_imp      registered quotient           (+ err_imp,      valid_out_imp)
//   busy_imp       divider is in RUN or DONE; new divider requests ignored
//   d_rem_imp      remainder, sign of the dividend (only with DIV_REMAINDER_EN)
//
// Configuration:
//   DIV_REMAINDER_EN  when defined, adds the d_rem_imp output and its logic.
// ---------------------------------------------------------------------------
module dif_prod_imp_unit #(
    parameter int W = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] n1,
    input  logic signed [W-1:0] n2,
    input  logic                valid_in,
    output logic signed [W-1:0] d_out_dif,
    output logic                valid_out_dif,
    output logic                ovrflow_dif,
    output logic signed [W-1:0] d_out_prod,
    output logic                valid_out_prod,
    output logic                ovrflow_prod,
    output logic signed [W-1:0] d_out_imp,
    output logic                valid_out_imp,
    output logic                err_imp,
    output logic                busy_imp
`ifdef DIV_REMAINDER_EN
    ,
    output logic signed [W-1:0] d_rem_imp
`endif
);

    // Iteration counter runs 0..W-1 while in RUN.
    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Difference / product path state
    // -----------------------------------------------------------------------
    logic signed [W-1:0] dif_d,      dif_q;
    logic                ovf_dif_d,  ovf_dif_q;
    logic signed [W-1:0] prod_d,     prod_q;
    logic                ovf_prod_d, ovf_prod_q;
    logic                pulse_dp_d, pulse_dp_q;

    logic signed [W-1:0]   diff;
    logic signed [2*W-1:0] n1_x;
    logic signed [2*W-1:0] n2_x;
    logic signed [2*W-1:0] prod_full;
    logic        [W:0]     prod_upper;

    // -----------------------------------------------------------------------
    // Divider state
    // -----------------------------------------------------------------------
    state_t              state_d,   state_q;
    logic [CW-1:0]       cnt_d,     cnt_q;
    logic [W-1:0]        quo_d,     quo_q;    // dividend shifts out, quotient shifts in
    logic [W-1:0]        rem_d,     rem_q;    // partial remainder magnitude
    logic [W-1:0]        dvsr_d,    dvsr_q;   // divisor magnitude
    logic                q_neg_d,   q_neg_q;
    logic                zero_d,    zero_q;   // divisor was zero
    logic                ovf_div_d, ovf_div_q; // -2^(W-1) / -1
    logic signed [W-1:0] imp_d,     imp_q;
    logic                err_d,     err_q;
    logic                vimp_d,    vimp_q;
`ifdef DIV_REMAINDER_EN
    logic                r_neg_d,   r_neg_q;
    logic signed [W-1:0] rem_out_d, rem_out_q;
`endif

    logic [W-1:0] n1_mag;
    logic [W-1:0] n2_mag;
    logic [W:0]   rem_sh;
    logic [W:0]   rem_sub;

    // -----------------------------------------------------------------------
    // Difference and product: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        dif_d      = dif_q;
        ovf_dif_d  = ovf_dif_q;
        prod_d     = prod_q;
        ovf_prod_d = ovf_prod_q;
        pulse_dp_d = valid_in;

        diff       = n1 - n2;
        n1_x       = {{W{n1[W-1]}}, n1};
        n2_x       = {{W{n2[W-1]}}, n2};
        prod_full  = n1_x * n2_x;
        prod_upper = prod_full[2*W-1:W-1];

        if (valid_in) begin
            dif_d      = diff;
            // Overflow only possible when the operand signs differ.
            ovf_dif_d  = (n1[W-1] != n2[W-1]) && (diff[W-1] != n1[W-1]);
            prod_d     = prod_full[W-1:0];
            // Fits in W signed bits only if the top W+1 bits are a pure
            // sign extension.
            ovf_prod_d = !((&prod_upper) || (~|prod_upper));
        end
    end

    // -----------------------------------------------------------------------
    // Divider: next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        q_neg_d   = q_neg_q;
        zero_d    = zero_q;
        ovf_div_d = ovf_div_q;
        imp_d     = imp_q;
        err_d     = err_q;
        vimp_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
        r_neg_d   = r_neg_q;
        rem_out_d = rem_out_q;
`endif

        // Magnitudes are taken as unsigned W-bit values, so -2^(W-1)
        // becomes 2^(W-1) without overflowing.
        n1_mag  = n1[W-1] ? W'(-n1) : W'(n1);
        n2_mag  = n2[W-1] ? W'(-n2) : W'(n2);

        // One restoring step: shift the next dividend bit into the partial
        // remainder and try to subtract the divisor.
        rem_sh  = {rem_q, quo_q[W-1]};
        rem_sub = rem_sh - {1'b0, dvsr_q};

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    quo_d     = n1_mag;
                    rem_d     = '0;
                    dvsr_d    = n2_mag;
                    cnt_d     = '0;
                    q_neg_d   = n1[W-1] ^ n2[W-1];
                    zero_d    = (n2 == '0);
                    ovf_div_d = (n1 == MIN_VAL) && (n2 == '1);
`ifdef DIV_REMAINDER_EN
                    r_neg_d   = n1[W-1];
`endif
                    // A zero divisor has nothing to iterate on.
                    state_d   = (n2 == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                if (rem_sub[W]) begin
                    // Borrow: divisor did not fit, keep the shifted value.
                    rem_d = rem_sh[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end else begin
                    rem_d = rem_sub[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end

                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                vimp_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    imp_d = '0;
                    err_d = 1'b1;
                end else if (ovf_div_q) begin
                    imp_d = MIN_VAL;
                    err_d = 1'b1;
                end else begin
                    imp_d = q_neg_q ? -quo_q : quo_q;
                    err_d = 1'b0;
                end
`ifdef DIV_REMAINDER_EN
                if (zero_q || ovf_div_q) begin
                    rem_out_d = '0;
                end else begin
                    rem_out_d = r_neg_q ? -rem_q : rem_q;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    // NOTE: the divider's working registers are reset as well, so a
    // division aborted by reset leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dif_q      <= '0;
            ovf_dif_q  <= 1'b0;
            prod_q     <= '0;
            ovf_prod_q <= 1'b0;
            pulse_dp_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            q_neg_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_div_q  <= 1'b0;
            imp_q      <= '0;
            err_q      <= 1'b0;
            vimp_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
            r_neg_q    <= 1'b0;
            rem_out_q  <= '0;
`endif
        end else begin
            dif_q      <= dif_d;
            ovf_dif_q  <= ovf_dif_d;
            prod_q     <= prod_d;
            ovf_prod_q <= ovf_prod_d;
            pulse_dp_q <= pulse_dp_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            q_neg_q    <= q_neg_d;
            zero_q     <= zero_d;
            ovf_div_q  <= ovf_div_d;
            imp_q      <= imp_d;
            err_q      <= err_d;
            vimp_q     <= vimp_d;
`ifdef DIV_REMAINDER_EN
            r_neg_q    <= r_neg_d;
            rem_out_q  <= rem_out_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign d_out_dif      = dif_q;
    assign ovrflow_dif    = ovf_dif_q;
    assign valid_out_dif  = pulse_dp_q;
    assign d_out_prod     = prod_q;
    assign ovrflow_prod   = ovf_prod_q;
    assign valid_out_prod = pulse_dp_q;
    assign d_out_imp      = imp_q;
    assign err_imp        = err_q;
    assign valid_out_imp  = vimp_q;
    assign busy_imp       = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
    assign d_rem_imp      = rem_out_q;
`endif

endmodule

// File: tb/tb_dif_prod_imp_unit.sv
// ---------------------------------------------------------------------------
// tb_dif_prod_imp_unit
//
// Self-checking bench for dif_prod_imp_unit. Expected values come from a
// plain integer-arithmetic model (longint difference, product, division and
// remainder, with range tests for the flags). Directed operand pairs cover
// the worked examples and corner cases, followed by random operands, a
// request issued while the divider is busy, and a reset mid-division.
// ---------------------------------------------------------------------------
module tb_dif_prod_imp_unit;

    localparam int    W    = 28;
    localparam longint MINV = -(longint'(1) << (W - 1));
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] n1;
    logic signed [W-1:0] n2;
    logic                valid_in;
    logic signed [W-1:0] d_out_dif;
    logic                valid_out_dif;
    logic                ovrflow_dif;
    logic signed [W-1:0] d_out_prod;
    logic                valid_out_prod;
    logic                ovrflow_prod;
    logic signed [W-1:0] d_out_imp;
    logic                valid_out_imp;
    logic                err_imp;
    logic                busy_imp;
`ifdef DIV_REMAINDER_EN
    logic signed [W-1:0] d_rem_imp;
`endif

    int total = 0;
    int bad   = 0;

    dif_prod_imp_unit #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .n1             (n1),
        .n2             (n2),
        .valid_in       (valid_in),
        .d_out_dif      (d_out_dif),
        .valid_out_dif  (valid_out_dif),
        .ovrflow_dif    (ovrflow_dif),
        .d_out_prod     (d_out_prod),
        .valid_out_prod (valid_out_prod),
        .ovrflow_prod   (ovrflow_prod),
        .d_out_imp      (d_out_imp),
        .valid_out_imp  (valid_out_imp),
        .err_imp        (err_imp),
        .busy_imp       (busy_imp)
`ifdef DIV_REMAINDER_EN
        ,
        .d_rem_imp      (d_rem_imp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Truncate a model value to W bits, two's complement.
    function automatic logic signed [W-1:0] tr(input longint v);
        return v[W-1:0];
    endfunction

    function automatic logic out_of_range(input longint v);
        return (v < MINV) || (v > MAXV);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one operand pair and follow all three paths to completion.
    // With inject=1, a second pair (c,d) is offered while the divider is busy:
    // the difference/product paths must take it, the divider must not.
    task automatic run_op(input longint a, input longint b,
                          input bit inject, input longint c, input longint d);
        logic signed [W-1:0] e_dif, e_prod, e_q, e_r, e_dif2, e_prod2;
        logic                e_odif, e_oprod, e_err;
        int                  e_lat, lat, got, k;

        e_dif   = tr(a - b);
        e_odif  = out_of_range(a - b);
        e_prod  = tr(a * b);
        e_oprod = out_of_range(a * b);
        e_err   = (b == 0) || (a == MINV && b == -1);
        if (b == 0) begin
            e_q = '0;
            e_r = '0;
        end else begin
            e_q = tr(a / b);
            e_r = e_err ? '0 : tr(a % b);
        end
        e_lat   = (b == 0) ? 1 : W + 1;
        e_dif2  = tr(c - d);
        e_prod2 = tr(c * d);

        k = 0;
        while (busy_imp && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_before_op", busy_imp, 0);

        @(negedge clk);
        n1 = tr(a);
        n2 = tr(b);
        valid_in = 1'b1;
        @(posedge clk); #1;
        chk("dif", d_out_dif, e_dif);
        chk("ovrflow_dif", ovrflow_dif, e_odif);
        chk("valid_out_dif", valid_out_dif, 1);
        chk("prod", d_out_prod, e_prod);
        chk("ovrflow_prod", ovrflow_prod, e_oprod);
        chk("valid_out_prod", valid_out_prod, 1);
        chk("busy_after_sample", busy_imp, 1);

        @(negedge clk);
        valid_in = 1'b0;
        n1 = W'($urandom);
        n2 = W'($urandom);

        got = 0;
        lat = 0;
        for (int e = 1; e <= W + 4; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                chk("dif_pulse_end", valid_out_dif, 0);
                chk("dif_hold", d_out_dif, e_dif);
            end
            if (valid_out_imp) begin
                if (got == 0) begin
                    lat = e;
                    chk("imp", d_out_imp, e_q);
                    chk("err_imp", err_imp, e_err);
`ifdef DIV_REMAINDER_EN
                    chk("rem_imp", d_rem_imp, e_r);
`endif
                end
                got++;
            end
            if (inject && e == 3) begin
                n1 = tr(c);
                n2 = tr(d);
                valid_in = 1'b1;
            end
            if (inject && e == 4) begin
                chk("busy_dif", d_out_dif, e_dif2);
                chk("busy_prod", d_out_prod, e_prod2);
                chk("busy_valid_dif", valid_out_dif, 1);
                chk("busy_flag", busy_imp, 1);
                valid_in = 1'b0;
            end
        end
        chk("imp_latency", lat, e_lat);
        chk("imp_pulse_count", got, 1);
        chk("imp_hold", d_out_imp, e_q);
        chk("idle_after_op", busy_imp, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dif"},   d_out_dif, 0);
        chk({tag, "_vdif"},  valid_out_dif, 0);
        chk({tag, "_odif"},  ovrflow_dif, 0);
        chk({tag, "_prod"},  d_out_prod, 0);
        chk({tag, "_vprod"}, valid_out_prod, 0);
        chk({tag, "_oprod"}, ovrflow_prod, 0);
        chk({tag, "_imp"},   d_out_imp, 0);
        chk({tag, "_vimp"},  valid_out_imp, 0);
        chk({tag, "_err"},   err_imp, 0);
        chk({tag, "_busy"},  busy_imp, 0);
`ifdef DIV_REMAINDER_EN
        chk({tag, "_rem"},   d_rem_imp, 0);
`endif
    endtask

    initial begin
        logic signed [W-1:0] ra, rb;
        int pulses;

        rst      = 1'b0;
        valid_in = 1'b0;
        n1       = '0;
        n2       = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Worked examples and corner cases.
        run_op(412, 3534, 0, 0, 0);
        chk("example_dif", d_out_dif, -3122);
        run_op(99999900, 120, 0, 0, 0);
        run_op(-2556, 0, 0, 0, 0);
        run_op(-96091078, -5346, 0, 0, 0);
        run_op(169, 13, 0, 0, 0);
        run_op(168, 13, 0, 0, 0);
        run_op(MINV, -1, 0, 0, 0);
        run_op(MAXV, MINV, 0, 0, 0);
        run_op(MINV, 1, 0, 0, 0);
        run_op(-7, 2, 0, 0, 0);
        run_op(7, -7, 0, 0, 0);

        // Request arriving while the divider is busy.
        run_op(1000000, -7, 1, 5, -9);

        // Random operands: half with wide divisors, half with small ones.
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            if (i % 2 == 0) begin
                rb = W'($urandom);
            end else begin
                rb = W'($urandom_range(0, 2000));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            run_op(ra, rb, 0, 0, 0);
        end

        // Reset in the middle of a division, with a busy-time request.
        @(negedge clk);
        n1 = tr(123456);
        n2 = tr(-77);
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n1 = tr(11);
        n2 = tr(3);
        valid_in = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy_imp, 1);
        valid_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int e = 0; e < W + 4; e++) begin
            @(posedge clk); #1;
            if (valid_out_imp) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk_all_zero("after_abort");

        // First request after reset is processed normally.
        run_op(-1000, 33, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
